// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer: owns PC/IR, fetches over req/ack, steps FETCH/DECODE/EXEC/MEM/IO/WB.
// 4 cycles ALU/jump, 5 LOAD/STORE, 5+wait IO; fetch stalls on missing imem_ack, IO waits on in_valid/out_ready up to IO_TIMEOUT.
module multicycle_sequencer #(
    parameter int PC_W       = 8,
    parameter int IO_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instr,
    output logic [2:0]      opcode,
    input  logic            cu_write_reg,
    input  logic            cu_rom_read,
    input  logic            cu_rom_write,
    input  logic            cu_read_strobe,
    input  logic            cu_write_strobe,
    input  logic            cu_jump_neq,
    input  logic            alu_zero,
    output logic            reg_we,
    output logic            rom_re,
    output logic            rom_we,
    output logic            read_strobe,
    output logic            write_strobe,
    input  logic            in_valid,
    input  logic            out_ready,
    output logic            retire,
    output logic            io_timeout,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_IO, S_WB
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(IO_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              taken_q, taken_d;
    logic              abort_q, abort_d;
    logic [15:0]       wait_q, wait_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       jump_off;
    logic              io_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            ir_q    <= '0;
            taken_q <= 1'b0;
            abort_q <= 1'b0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
            abort_q <= abort_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    // Branch offset is sign-extended to 16 bits, then truncated so PC arithmetic wraps mod 2^PC_W.
    assign jump_off = {{9{ir_q[6]}}, ir_q[6:0]};
    assign io_hs    = (cu_read_strobe & in_valid) | (cu_write_strobe & out_ready);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        taken_d      = taken_q;
        abort_d      = abort_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        imem_req     = 1'b0;
        reg_we       = 1'b0;
        rom_re       = 1'b0;
        rom_we       = 1'b0;
        read_strobe  = 1'b0;
        write_strobe = 1'b0;
        retire       = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                taken_d = cu_jump_neq & ~alu_zero;
                abort_d = 1'b0;
                wait_d  = '0;
                case (ir_q[15:13])
                    3'b010, 3'b011: state_d = S_MEM;
                    3'b000, 3'b001: state_d = S_IO;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                rom_re  = cu_rom_read;
                rom_we  = cu_rom_write;
                state_d = S_WB;
            end
            S_IO: begin
                read_strobe  = cu_read_strobe;
                write_strobe = cu_write_strobe;
                // A handshake in the final allowed cycle still completes normally.
                if (io_hs) begin
                    state_d = S_WB;
                end else if (wait_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WB: begin
                reg_we  = cu_write_reg & ~abort_q;
                retire  = 1'b1;
                pc_d    = pc_q + PC_W'(1) + (taken_q ? jump_off[PC_W-1:0] : '0);
                taken_d = 1'b0;
                state_d = S_FETCH;
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign imem_addr  = pc_q;
    assign instr      = ir_q;
    assign opcode     = ir_q[15:13];
    assign io_timeout = tmo_q;
    assign busy       = (state_q != S_BOOT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: phase-level reference model compared every cycle, plus literal cycle/PC checks.
module tb_multicycle_sequencer;

    localparam int PC_W = 8;
    localparam int TMO  = 7;
    localparam int PC_MOD = 1 << PC_W;

    localparam int P_BOOT = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_IO = 5, P_WB = 6;

    typedef struct packed {
        logic wr;
        logic rr;
        logic rw;
        logic rs;
        logic ws;
        logic jne;
    } cu_t;

    logic            clk;
    logic            rst_n;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic [15:0]     instr;
    logic [2:0]      opcode;
    logic            cu_write_reg, cu_rom_read, cu_rom_write;
    logic            cu_read_strobe, cu_write_strobe, cu_jump_neq;
    logic            alu_zero;
    logic            reg_we, rom_re, rom_we, read_strobe, write_strobe;
    logic            in_valid, out_ready;
    logic            retire, io_timeout, busy;

    multicycle_sequencer #(.PC_W(PC_W), .IO_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode),
        .cu_write_reg(cu_write_reg), .cu_rom_read(cu_rom_read), .cu_rom_write(cu_rom_write),
        .cu_read_strobe(cu_read_strobe), .cu_write_strobe(cu_write_strobe), .cu_jump_neq(cu_jump_neq),
        .alu_zero(alu_zero),
        .reg_we(reg_we), .rom_re(rom_re), .rom_we(rom_we),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .in_valid(in_valid), .out_ready(out_ready),
        .retire(retire), .io_timeout(io_timeout), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control unit: INPUT 000, OUTPUT 001, LOAD 010, STORE 011, ALU 100/101/110, JNE 111.
    function automatic cu_t cu_of(input logic [2:0] op);
        cu_t c;
        c     = '0;
        c.wr  = (op == 3'b000) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
        c.rr  = (op == 3'b010);
        c.rw  = (op == 3'b011);
        c.rs  = (op == 3'b000);
        c.ws  = (op == 3'b001);
        c.jne = (op == 3'b111);
        return c;
    endfunction

    always_comb begin
        {cu_write_reg, cu_rom_read, cu_rom_write, cu_read_strobe, cu_write_strobe, cu_jump_neq} = cu_of(opcode);
    end

    logic [15:0] mem [PC_MOD];

    int n_vec = 0, n_err = 0, cyc = 0;

    int          m_st, m_pc, m_io;
    logic [15:0] m_ir;
    logic        m_taken, m_abort, m_tmo;

    int k_ack, k_io, k_az, k_stray, k_fiv;
    int fcnt, iocnt;

    int fa, req_cyc, ret_cyc, prev_ret, regwe_cyc, rom_cyc, n_rom, n_ws, n_rs, rel_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        cu_t c;
        int  nxt, off;
        c = cu_of(m_ir[15:13]);
        if (!rst_n) begin
            m_st = P_BOOT; m_pc = 0; m_ir = '0; m_taken = 0; m_abort = 0; m_io = 0; m_tmo = 0;
            return;
        end
        case (m_st)
            P_BOOT:  m_st = P_FETCH;
            P_FETCH: if (imem_ack) begin m_ir = imem_data; m_st = P_DEC; end
            P_DEC:   m_st = P_EXEC;
            P_EXEC: begin
                m_taken = c.jne && !alu_zero;
                m_abort = 0;
                m_io    = 0;
                if (m_ir[15:13] == 3'd2 || m_ir[15:13] == 3'd3) m_st = P_MEM;
                else if (m_ir[15:13] < 3'd2)                    m_st = P_IO;
                else                                            m_st = P_WB;
            end
            P_MEM: m_st = P_WB;
            P_IO: begin
                m_io++;
                if ((c.rs && in_valid) || (c.ws && out_ready)) m_st = P_WB;
                else if (m_io == TMO) begin m_tmo = 1; m_abort = 1; m_st = P_WB; end
            end
            P_WB: begin
                off  = m_ir[6] ? int'(m_ir[6:0]) - 128 : int'(m_ir[6:0]);
                nxt  = m_pc + 1 + (m_taken ? off : 0);
                m_pc = ((nxt % PC_MOD) + PC_MOD) % PC_MOD;
                m_taken = 0;
                m_st = P_FETCH;
            end
            default: m_st = P_BOOT;
        endcase
    endtask

    task automatic compare();
        cu_t c;
        c = cu_of(m_ir[15:13]);
        chk("busy",         32'(busy),         32'(m_st != P_BOOT));
        chk("imem_req",     32'(imem_req),     32'(m_st == P_FETCH));
        chk("imem_addr",    32'(imem_addr),    32'(m_pc));
        chk("instr",        32'(instr),        32'(m_ir));
        chk("opcode",       32'(opcode),       32'(m_ir[15:13]));
        chk("reg_we",       32'(reg_we),       32'(m_st == P_WB && c.wr && !m_abort));
        chk("rom_re",       32'(rom_re),       32'(m_st == P_MEM && c.rr));
        chk("rom_we",       32'(rom_we),       32'(m_st == P_MEM && c.rw));
        chk("read_strobe",  32'(read_strobe),  32'(m_st == P_IO && c.rs));
        chk("write_strobe", 32'(write_strobe), 32'(m_st == P_IO && c.ws));
        chk("retire",       32'(retire),       32'(m_st == P_WB));
        chk("io_timeout",   32'(io_timeout),   32'(m_tmo));
    endtask

    // Environment: memory with scripted ack delay, scripted IO handshake, noise on ignored inputs.
    task automatic drive();
        cu_t c;
        c         = cu_of(m_ir[15:13]);
        imem_ack  = 1'b0;
        imem_data = 16'hFFFF;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_zero  = (k_az != 0);
        if (!rst_n) begin
            imem_ack = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            fcnt = 0; iocnt = 0;
            return;
        end
        if (m_st == P_FETCH) begin
            imem_ack = (fcnt == k_ack);
            if (imem_ack) imem_data = mem[imem_addr];
            in_valid = (k_fiv != 0);
            fcnt++;
        end else begin
            fcnt     = 0;
            imem_ack = (k_stray != 0);
        end
        if (m_st == P_IO) begin
            if (c.rs) in_valid = (iocnt == k_io);
            if (c.ws) begin out_ready = (iocnt == k_io); in_valid = 1'b1; end
            iocnt++;
        end else begin
            iocnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
        drive();
        if (imem_req && req_cyc < 0) begin req_cyc = cyc; fa = int'(imem_addr); end
        if (rom_re) begin n_rom++; rom_cyc = cyc; end
        if (write_strobe) n_ws++;
        if (read_strobe) n_rs++;
        if (reg_we) regwe_cyc = cyc;
    endtask

    task automatic start(input int ack, input int io, input int az, input int stray, input int fiv);
        k_ack = ack; k_io = io; k_az = az; k_stray = stray; k_fiv = fiv;
        fa = -1; req_cyc = -1; regwe_cyc = -1; rom_cyc = -1;
        n_rom = 0; n_ws = 0; n_rs = 0;
        prev_ret = ret_cyc; ret_cyc = -1;
    endtask

    task automatic run_instr(input int ack, input int io, input int az, input int stray, input int fiv);
        start(ack, io, az, stray, fiv);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (retire) begin ret_cyc = cyc; break; end
        end
        if (ret_cyc < 0) chk("retire_seen", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        drive();
        rel_cyc = cyc;
        ret_cyc = cyc;
    endtask

    initial begin
        for (int a = 0; a < PC_MOD; a++) mem[a] = 16'hA000;
        mem[0]   = 16'h8123;   // ADD
        mem[1]   = 16'h4005;   // LOAD
        mem[2]   = 16'h2000;   // OUTPUT
        mem[3]   = 16'h0001;   // INPUT
        mem[4]   = 16'h6002;   // STORE
        mem[5]   = 16'hE004;   // JNE +4   -> 10
        mem[10]  = 16'hE07C;   // JNE -4   -> 7 when taken
        mem[7]   = 16'hE002;   // JNE +2   -> 10
        mem[11]  = 16'hE073;   // JNE -13  -> 255
        mem[255] = 16'hE010;   // JNE untaken -> wraps to 0
        k_ack = 0; k_io = -1; k_az = 0; k_stray = 0; k_fiv = 0;
        fcnt = 0; iocnt = 0; ret_cyc = 0;
        m_st = P_BOOT; m_pc = 0; m_ir = '0; m_taken = 0; m_abort = 0; m_io = 0; m_tmo = 0;
        rst_n = 1'b0;
        drive();

        do_reset();
        chk("boot_busy", 32'(busy), 32'd0);
        chk("boot_req",  32'(imem_req), 32'd0);

        run_instr(0, -1, 0, 0, 0);                        // ADD @0
        chk("add_req_cycle",    32'(req_cyc - rel_cyc + 1), 32'd2);
        chk("add_retire_cycle", 32'(ret_cyc - rel_cyc + 1), 32'd5);
        chk("add_regwe_cycle",  32'(regwe_cyc - rel_cyc + 1), 32'd5);
        chk("add_pc",           32'(fa), 32'd0);

        run_instr(3, -1, 0, 0, 0);                        // LOAD @1, ack delayed 3
        chk("load_pc",     32'(fa), 32'd1);
        chk("load_cpi",    32'(ret_cyc - prev_ret), 32'd8);
        chk("load_rom_re", 32'(n_rom), 32'd1);
        chk("load_regwe",  32'(regwe_cyc - rom_cyc), 32'd1);

        run_instr(0, 6, 0, 0, 0);                         // OUTPUT @2, ready in 7th IO cycle
        chk("out_pc",      32'(fa), 32'd2);
        chk("out_ws_len",  32'(n_ws), 32'd7);
        chk("out_cpi",     32'(ret_cyc - prev_ret), 32'd11);
        chk("out_tmo",     32'(io_timeout), 32'd0);

        run_instr(0, -1, 0, 0, 0);                        // INPUT @3, never valid
        chk("in_pc",       32'(fa), 32'd3);
        chk("in_rs_len",   32'(n_rs), 32'd7);
        chk("in_tmo",      32'(io_timeout), 32'd1);
        chk("in_regwe",    32'(regwe_cyc), 32'hFFFF_FFFF);

        run_instr(2, -1, 0, 1, 1);                        // STORE @4, in_valid noise in FETCH, stray acks
        chk("store_pc",    32'(fa), 32'd4);
        chk("store_cpi",   32'(ret_cyc - prev_ret), 32'd7);

        run_instr(0, -1, 0, 0, 0);                        // JNE @5 taken
        chk("jne5_pc",     32'(fa), 32'd5);
        chk("jne5_cpi",    32'(ret_cyc - prev_ret), 32'd4);
        run_instr(0, -1, 0, 0, 0);                        // JNE @10 taken -4
        chk("jne10a_pc",   32'(fa), 32'd10);
        run_instr(0, -1, 0, 0, 0);                        // JNE @7 taken
        chk("jne_back_pc", 32'(fa), 32'd7);
        run_instr(0, -1, 1, 0, 0);                        // JNE @10 untaken
        chk("jne10b_pc",   32'(fa), 32'd10);
        run_instr(0, -1, 0, 0, 0);                        // JNE @11 taken -13
        chk("jne11_pc",    32'(fa), 32'd11);
        run_instr(0, -1, 1, 0, 0);                        // JNE @255 untaken
        chk("jne255_pc",   32'(fa), 32'd255);
        run_instr(0, -1, 0, 0, 0);                        // ADD after wrap
        chk("wrap_pc",     32'(fa), 32'd0);
        run_instr(0, -1, 0, 0, 0);                        // LOAD @1

        start(0, -1, 0, 0, 0);                            // OUTPUT @2, reset after 3 IO cycles
        for (int i = 0; i < 30 && n_ws < 3; i++) tick();
        chk("mid_io_ws", 32'(n_ws), 32'd3);
        rst_n = 1'b0;
        drive();
        tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_ws",     32'(write_strobe), 32'd0);
        chk("rst_tmo",    32'(io_timeout), 32'd0);
        chk("rst_pc",     32'(imem_addr), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        rst_n = 1'b1;
        drive();
        rel_cyc = cyc;
        ret_cyc = cyc;
        run_instr(0, -1, 0, 0, 0);
        chk("rst_add_pc",     32'(fa), 32'd0);
        chk("rst_add_retire", 32'(ret_cyc - rel_cyc + 1), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
